// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   typedef enum logic {PORT_I, PORT_D} port_e;

   localparam int unsigned DEFAULT_LAT = 4;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with a zero flag, used to time the backend latency.
module lat_counter #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch (I) and data (D) accesses onto one fixed-latency memory,
// returning read data with a one-cycle done pulse and driving pipeline stalls.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LAT = DEFAULT_LAT,
   parameter int unsigned AW  = 16,
   parameter int unsigned DW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic          d_wr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_dump,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_dump,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = $clog2(LAT) + 1;

   state_e        state_q, state_d;
   port_e         owner_q, owner_d;
   port_e         last_q, last_d;
   port_e         grant;
   logic [AW-1:0] addr_q, addr_d;
   logic          wr_q, wr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          dump_q, dump_d;
   logic [DW-1:0] i_rdata_q, d_rdata_q;
   logic          cnt_load, cnt_dec, cnt_zero, capture;

   lat_counter #(
      .W (CW)
   ) u_lat_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (CW'(LAT - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      dump_d   = dump_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      capture  = 1'b0;
      // D wins a tie unless it also won the previous grant, so I cannot starve.
      grant    = (d_req && (!i_req || (last_q != PORT_D))) ? PORT_D : PORT_I;

      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d = ISSUE;
               owner_d = grant;
               last_d  = grant;
               if (grant == PORT_D) begin
                  addr_d  = d_addr;
                  wr_d    = d_wr;
                  wdata_d = d_wdata;
                  dump_d  = d_dump;
               end else begin
                  addr_d = i_addr;
                  wr_d   = 1'b0;
                  dump_d = 1'b0;
               end
            end
         end
         ISSUE: begin
            cnt_load = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (cnt_zero) begin
               capture = 1'b1;
               state_d = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= PORT_I;
         last_q    <= PORT_I;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         dump_q    <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         dump_q  <= dump_d;
         if (capture && !wr_q) begin
            if (owner_q == PORT_I) begin
               i_rdata_q <= mem_rdata;
            end else begin
               d_rdata_q <= mem_rdata;
            end
         end
      end
   end

   assign mem_en    = (state_q == ISSUE);
   assign mem_wr    = wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_dump  = dump_q;

   assign i_done    = (state_q == RESP) && (owner_q == PORT_I);
   assign d_done    = (state_q == RESP) && (owner_q == PORT_D);
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

   assign stall_if  = i_req & ~i_done;
   assign stall_mem = d_req & ~d_done;

endmodule
